// File: rtl/simon_param_core.sv
`default_nettype none
// ============================================================================
// Module   : simon_param_core
// Brief    : Iterative Simon block-cipher engine for the 32-, 48- and 64-bit
//            block variants. A loaded key is expanded once into an internal
//            round-key file, then blocks are processed one round per cycle
//            under valid/ready handshakes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WORD_W     word size n (16, 24 or 32); block is 2*WORD_W bits
//   KEY_WORDS  key words m; legal pairs 16/4, 24/3, 24/4, 32/3, 32/4
// Build option:
//   SIMON_DECRYPT_EN  when defined, 'mode' selects encrypt (0) or decrypt
//                     (1); when undefined every block is encrypted.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   key_load    single-cycle request to load and expand keytext
//   keytext     key words, lowest word is k0
//   key_ready   round-key file is valid
//   in_valid    input block valid
//   in_ready    core can accept a block (high only when idle with a key)
//   mode        0 = encrypt, 1 = decrypt, sampled on accept
//   plaintext   input block {x, y}, x in the upper word
//   out_valid   ciphertext is valid
//   out_ready   downstream accepts the result
//   ciphertext  result block {x, y}
// ============================================================================
module simon_param_core #(
    parameter int WORD_W    = 16,
    parameter int KEY_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_load,
    input  logic [KEY_WORDS*WORD_W-1:0] keytext,
    output logic                        key_ready,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        mode,
    input  logic [2*WORD_W-1:0]         plaintext,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*WORD_W-1:0]         ciphertext
);

    localparam bit c_legal = (WORD_W == 16 && KEY_WORDS == 4) ||
                             (WORD_W == 24 && KEY_WORDS == 3) ||
                             (WORD_W == 24 && KEY_WORDS == 4) ||
                             (WORD_W == 32 && KEY_WORDS == 3) ||
                             (WORD_W == 32 && KEY_WORDS == 4);

    localparam int ROUNDS = (WORD_W == 16) ? 32 :
                            (WORD_W == 24) ? 36 :
                            (KEY_WORDS == 3) ? 42 : 44;

    localparam int Z_SEL  = (WORD_W == 16) ? 0 :
                            (WORD_W == 24 && KEY_WORDS == 3) ? 0 :
                            (WORD_W == 24) ? 1 :
                            (KEY_WORDS == 3) ? 2 : 3;

    localparam int c_idx_w    = $clog2(ROUNDS);
    // Key file is rounded up to a power of two so every index value is in range.
    localparam int c_kf_depth = 1 << c_idx_w;

    localparam logic [c_idx_w-1:0] c_rnd_last  = c_idx_w'(ROUNDS - 1);
    localparam logic [c_idx_w-1:0] c_kexp_last = c_idx_w'(ROUNDS - KEY_WORDS - 1);
    localparam logic [c_idx_w-1:0] c_m         = c_idx_w'(KEY_WORDS);
    localparam logic [c_idx_w-1:0] c_one       = c_idx_w'(1);
    localparam logic [WORD_W-1:0]  c_three     = WORD_W'(3);

    // Constant sequences, z[0] is the leftmost (most significant) bit.
    localparam logic [61:0] c_z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] c_z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] c_z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] c_z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] c_z  = (Z_SEL == 0) ? c_z0 :
                                   (Z_SEL == 1) ? c_z1 :
                                   (Z_SEL == 2) ? c_z2 : c_z3;

    localparam logic [2:0] c_st_nokey  = 3'd0;
    localparam logic [2:0] c_st_keyexp = 3'd1;
    localparam logic [2:0] c_st_idle   = 3'd2;
    localparam logic [2:0] c_st_run    = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    generate
        if (!c_legal) begin : g_bad_params
            $error("simon_param_core: illegal WORD_W/KEY_WORDS pair");
        end
    endgenerate

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v, input int s);
        rotl = (v << s) | (v >> (WORD_W - s));
    endfunction

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int s);
        rotr = rotl(v, WORD_W - s);
    endfunction

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [WORD_W-1:0]   r_kfile [0:c_kf_depth-1];
    logic [c_idx_w-1:0]  r_kidx;
    logic [c_idx_w-1:0]  r_rnd;
    logic [WORD_W-1:0]   r_x;
    logic [WORD_W-1:0]   r_y;

    logic                w_key_accept;
    logic                w_accept;
    logic                w_kexp_done;
    logic                w_rnd_done;
    logic [WORD_W-1:0]   w_load_x;
    logic [WORD_W-1:0]   w_load_y;
    logic [c_idx_w-1:0]  w_rnd_init;
    logic [c_idx_w-1:0]  w_rnd_step;

    logic [WORD_W-1:0]   w_k_i;
    logic [WORD_W-1:0]   w_k_top;
    logic [WORD_W-1:0]   w_tmp0;
    logic [WORD_W-1:0]   w_tmp;
    logic [5:0]          w_zidx;
    logic                w_zbit;
    logic [WORD_W-1:0]   w_k_new;
    logic [WORD_W-1:0]   w_k_rnd;
    logic [WORD_W-1:0]   w_fx;

    // key_load wins over in_valid, so an IDLE accept requires key_load low.
    assign w_key_accept = key_load && (r_state == c_st_nokey ||
                                       r_state == c_st_keyexp ||
                                       r_state == c_st_idle);
    assign w_accept     = (r_state == c_st_idle) && in_valid && !key_load;
    assign w_kexp_done  = (r_kidx == c_kexp_last);

    // ------------------------------------------------------------------
    // Key expansion: produce k(i+m) from the window starting at k(i).
    // ------------------------------------------------------------------
    assign w_k_i   = r_kfile[r_kidx];
    assign w_k_top = r_kfile[r_kidx + c_m - c_one];

    generate
        if (KEY_WORDS == 4) begin : g_tmp_m4
            assign w_tmp0 = rotr(w_k_top, 3) ^ r_kfile[r_kidx + c_one];
        end else begin : g_tmp_m3
            assign w_tmp0 = rotr(w_k_top, 3);
        end
    endgenerate

    assign w_tmp   = w_tmp0 ^ rotr(w_tmp0, 1);
    assign w_zidx  = 6'd61 - 6'(r_kidx);
    assign w_zbit  = c_z[w_zidx];
    assign w_k_new = ~w_k_i ^ w_tmp ^ {{(WORD_W-1){1'b0}}, w_zbit} ^ c_three;

    // ------------------------------------------------------------------
    // Round function
    // ------------------------------------------------------------------
    assign w_k_rnd = r_kfile[r_rnd];
    assign w_fx    = (rotl(r_x, 1) & rotl(r_x, 8)) ^ rotl(r_x, 2);

`ifdef SIMON_DECRYPT_EN
    logic r_mode;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= 1'b0;
        end else if (w_accept) begin
            r_mode <= mode;
        end
    end

    // Decrypt loads the halves swapped and walks the key file backwards;
    // the halves stay swapped in the registers and are undone at the output.
    assign w_load_x   = mode ? plaintext[WORD_W-1:0] : plaintext[2*WORD_W-1:WORD_W];
    assign w_load_y   = mode ? plaintext[2*WORD_W-1:WORD_W] : plaintext[WORD_W-1:0];
    assign w_rnd_init = mode ? c_rnd_last : '0;
    assign w_rnd_step = r_mode ? (r_rnd - c_one) : (r_rnd + c_one);
    assign w_rnd_done = r_mode ? (r_rnd == '0) : (r_rnd == c_rnd_last);
    assign ciphertext = r_mode ? {r_y, r_x} : {r_x, r_y};
`else
    logic w_unused_mode;

    assign w_unused_mode = mode;
    assign w_load_x      = plaintext[2*WORD_W-1:WORD_W];
    assign w_load_y      = plaintext[WORD_W-1:0];
    assign w_rnd_init    = '0;
    assign w_rnd_step    = r_rnd + c_one;
    assign w_rnd_done    = (r_rnd == c_rnd_last);
    assign ciphertext    = {r_x, r_y};
`endif

    // ------------------------------------------------------------------
    // Round-key file: contents are don't-care after reset, so no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_key_accept) begin
            for (int j = 0; j < KEY_WORDS; j++) begin
                r_kfile[c_idx_w'(j)] <= keytext[j*WORD_W +: WORD_W];
            end
        end else if (r_state == c_st_keyexp) begin
            r_kfile[r_kidx + c_m] <= w_k_new;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kidx <= '0;
            r_rnd  <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else begin
            if (w_key_accept) begin
                r_kidx <= '0;
            end else if (r_state == c_st_keyexp) begin
                r_kidx <= r_kidx + c_one;
            end

            if (w_accept) begin
                r_x   <= w_load_x;
                r_y   <= w_load_y;
                r_rnd <= w_rnd_init;
            end else if (r_state == c_st_run) begin
                r_x   <= r_y ^ w_fx ^ w_k_rnd;
                r_y   <= r_x;
                r_rnd <= w_rnd_step;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_nokey;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_nokey: begin
                if (key_load) w_state_nxt = c_st_keyexp;
            end
            c_st_keyexp: begin
                if (key_load)         w_state_nxt = c_st_keyexp;
                else if (w_kexp_done) w_state_nxt = c_st_idle;
            end
            c_st_idle: begin
                if (key_load)      w_state_nxt = c_st_keyexp;
                else if (in_valid) w_state_nxt = c_st_run;
            end
            c_st_run: begin
                if (w_rnd_done) w_state_nxt = c_st_done;
            end
            c_st_done: begin
                if (out_ready) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_nokey;
        endcase
    end

    always_comb begin
        key_ready = (r_state == c_st_idle) || (r_state == c_st_run) ||
                    (r_state == c_st_done);
        in_ready  = (r_state == c_st_idle);
        out_valid = (r_state == c_st_done);
    end

endmodule
`default_nettype wire

// File: tb/tb_simon_param_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_param_core
// Brief    : Scoreboard bench for simon_param_core. A 32/64 instance takes
//            directed and randomized traffic checked against a behavioural
//            Simon model; a 64/128 instance checks the wide known vector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_param_core;

`ifdef SIMON_DECRYPT_EN
    localparam bit c_dec_en = 1'b1;
`else
    localparam bit c_dec_en = 1'b0;
`endif

    localparam logic [63:0] c_key_a = 64'h1918_1110_0908_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         key_load, in_valid, mode, out_ready;
    logic [63:0]  keytext;
    logic [31:0]  plaintext, ciphertext;
    logic         key_ready, in_ready, out_valid;

    logic         b_key_load, b_in_valid, b_mode, b_out_ready;
    logic [127:0] b_keytext;
    logic [63:0]  b_plaintext, b_ciphertext;
    logic         b_key_ready, b_in_ready, b_out_valid;

    simon_param_core #(.WORD_W(16), .KEY_WORDS(4)) u_dut (
        .clk(clk), .rst(rst), .key_load(key_load), .keytext(keytext),
        .key_ready(key_ready), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .plaintext(plaintext), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext)
    );

    simon_param_core #(.WORD_W(32), .KEY_WORDS(4)) u_dut_b (
        .clk(clk), .rst(rst), .key_load(b_key_load), .keytext(b_keytext),
        .key_ready(b_key_ready), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mode(b_mode), .plaintext(b_plaintext), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .ciphertext(b_ciphertext)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [63:0] cur_key;
    bit          rand_bp  = 1'b0;

    // ---------------- behavioural reference model ----------------
    function automatic bit zbit(input int s, input int i);
        logic [61:0] z;
        case (s)
            0:       z = 62'b11111010001001010110000111001101111101000100101011000011100110;
            1:       z = 62'b10001110111110010011000010110101000111011111001001100001011010;
            2:       z = 62'b10101111011100000011010010011000101000010001111110010110110011;
            default: z = 62'b11011011101011000110010111100000010010001010011100110100001111;
        endcase
        return z[61 - i];
    endfunction

    function automatic logic [63:0] mrol(input logic [63:0] v, input int s, input int n);
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        return ((v << s) | (v >> (n - s))) & mask;
    endfunction

    function automatic logic [63:0] mf(input logic [63:0] v, input int n);
        return (mrol(v, 1, n) & mrol(v, 8, n)) ^ mrol(v, 2, n);
    endfunction

    function automatic logic [63:0] ref_crypt(input int n, input int m, input logic [127:0] key,
                                              input logic [63:0] blk, input bit dec);
        logic [63:0] k [0:43];
        logic [63:0] mask, x, y, tmp;
        int          t, zs;
        mask = (64'd1 << n) - 64'd1;
        if (n == 16)      begin t = 32; zs = 0; end
        else if (n == 24) begin t = 36; zs = (m == 3) ? 0 : 1; end
        else              begin t = (m == 3) ? 42 : 44; zs = (m == 3) ? 2 : 3; end
        for (int i = 0; i < m; i++) k[i] = 64'(key >> (i * n)) & mask;
        for (int i = m; i < t; i++) begin
            tmp = mrol(k[i-1], n - 3, n);
            if (m == 4) tmp = tmp ^ k[i-3];
            tmp  = tmp ^ mrol(tmp, n - 1, n);
            k[i] = (~k[i-m] & mask) ^ tmp ^ {63'd0, zbit(zs, i - m)} ^ 64'd3;
        end
        x = (blk >> n) & mask;
        y = blk & mask;
        if (!dec) begin
            for (int i = 0; i < t; i++) begin
                tmp = x; x = y ^ mf(x, n) ^ k[i]; y = tmp;
            end
        end else begin
            for (int i = t - 1; i >= 0; i--) begin
                tmp = y; y = x ^ mf(y, n) ^ k[i]; x = tmp;
            end
        end
        return (x << n) | y;
    endfunction

    function automatic logic [31:0] model_a(input logic [31:0] blk, input bit md);
        logic [63:0] r;
        r = ref_crypt(16, 4, {64'd0, cur_key}, {32'd0, blk}, md & c_dec_en);
        return r[31:0];
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic expired(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual timeout required event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic load_key(input logic [63:0] k);
        int lat;
        keytext  = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        cur_key  = k;
        chk("key_ready_low_after_load", 64'(key_ready), 64'd0);
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (key_ready) begin lat = c; break; end
        end
        if (lat < 0) expired("key_expand");
        else         chk("key_ready_latency", 64'(lat), 64'd28);
    endtask

    task automatic send(input logic [31:0] blk, input bit md);
        bit ok;
        in_valid  = 1'b1;
        plaintext = blk;
        mode      = md;
        ok        = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (in_ready) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            in_valid = 1'b0;
            expired("wait_in_ready");
            return;
        end
        tick();
        exp_q.push_back(model_a(blk, md));
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input int req_lat);
        int lat;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (out_valid) begin lat = c; break; end
        end
        if (lat < 0) expired(name);
        else         chk(name, 64'(lat), 64'(req_lat));
    endtask

    task automatic drain();
        for (int c = 0; c < 2000; c++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (exp_q.size() != 0) expired("drain_scoreboard");
        rand_bp   = 1'b0;
        out_ready = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: actual %h required none", ciphertext);
            end else begin
                chk("scoreboard_ciphertext", {32'd0, ciphertext}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          lat;
        int          seen;
        logic [31:0] blk;
        logic [31:0] e;
        logic [63:0] nk;

        rst = 1'b0;
        key_load = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1;
        keytext = '0; plaintext = '0;
        b_key_load = 1'b0; b_in_valid = 1'b0; b_mode = 1'b0; b_out_ready = 1'b1;
        b_keytext = '0; b_plaintext = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_key_ready",  64'(key_ready),  64'd0);
        chk("reset_in_ready",   64'(in_ready),   64'd0);
        chk("reset_out_valid",  64'(out_valid),  64'd0);
        chk("reset_ciphertext", 64'(ciphertext), 64'd0);
        #2 rst = 1'b1;
        tick();

        // 64/128 known vector on the wide instance
        b_keytext  = 128'h1b1a1918_13121110_0b0a0908_03020100;
        b_key_load = 1'b1;
        tick();
        b_key_load = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (b_key_ready) begin lat = c; break; end
        end
        if (lat < 0) expired("b_key_expand");
        else         chk("b_key_ready_latency", 64'(lat), 64'd40);
        chk("b_in_ready_idle", 64'(b_in_ready), 64'd1);
        b_plaintext = 64'h656b696c_20646e75;
        b_in_valid  = 1'b1;
        tick();
        b_in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (b_out_valid) begin lat = c; break; end
        end
        if (lat < 0) expired("b_out_valid");
        else begin
            chk("b_block_latency", 64'(lat), 64'd44);
            chk("b_ciphertext_vector", b_ciphertext, 64'h44c8fc20_b9dfa07a);
        end

        // 32/64 known vector with latencies
        load_key(c_key_a);
        send(32'h6565_6877, 1'b0);
        wait_out("block_latency", 32);
        chk("ciphertext_vector", 64'(ciphertext), 64'hc69b_e9bb);
        drain();

        // decrypt request (encrypts when the option is not built)
        send(32'hc69b_e9bb, 1'b1);
        wait_out("decrypt_latency", 32);
`ifdef SIMON_DECRYPT_EN
        chk("decrypt_vector", 64'(ciphertext), 64'h6565_6877);
`endif
        drain();

        // backpressure in DONE, key_load there is ignored
        out_ready = 1'b0;
        blk = $urandom();
        e   = model_a(blk, 1'b0);
        send(blk, 1'b0);
        wait_out("bp_latency", 32);
        for (int i = 0; i < 10; i++) begin
            chk("bp_ciphertext_stable", 64'(ciphertext), 64'(e));
            chk("bp_in_ready_low",      64'(in_ready),   64'd0);
            chk("bp_out_valid_held",    64'(out_valid),  64'd1);
            if (i == 3) begin
                keytext  = {$urandom(), $urandom()};
                key_load = 1'b1;
            end else begin
                key_load = 1'b0;
            end
            tick();
        end
        key_load = 1'b0;
        chk("bp_key_ready_kept", 64'(key_ready), 64'd1);
        out_ready = 1'b1;
        drain();
        send($urandom(), 1'b0);
        drain();

        // reset in the middle of RUN
        send($urandom(), 1'b0);
        repeat (10) tick();
        #2 rst = 1'b0;
        #1;
        chk("midrun_key_ready",  64'(key_ready),  64'd0);
        chk("midrun_in_ready",   64'(in_ready),   64'd0);
        chk("midrun_out_valid",  64'(out_valid),  64'd0);
        chk("midrun_ciphertext", 64'(ciphertext), 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("no_out_valid_after_reset", 64'(seen), 64'd0);
        chk("key_ready_after_reset", 64'(key_ready), 64'd0);
        load_key(c_key_a);
        send(32'h6565_6877, 1'b0);
        wait_out("block_latency_after_reset", 32);
        chk("ciphertext_vector_after_reset", 64'(ciphertext), 64'hc69b_e9bb);
        drain();

        // key_load and in_valid together in IDLE
        nk        = {$urandom(), $urandom()};
        keytext   = nk;
        plaintext = $urandom();
        key_load  = 1'b1;
        in_valid  = 1'b1;
        tick();
        key_load = 1'b0;
        in_valid = 1'b0;
        cur_key  = nk;
        chk("contention_key_ready", 64'(key_ready), 64'd0);
        chk("contention_in_ready",  64'(in_ready),  64'd0);
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (key_ready) begin lat = c; break; end
        end
        if (lat < 0) expired("contention_key_expand");
        else         chk("contention_key_latency", 64'(lat), 64'd28);

        // randomized traffic with random backpressure and modes
        rand_bp = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send($urandom(), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
